// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared ASCII constants and byte type
//
// Purpose: constants that define the printable ASCII set, plus the byte type
//          used by the ASCII stream blocks.
// Ports:   none (package).
package ascii_pkg;

  typedef logic [7:0] ascii_byte_t;

  localparam ascii_byte_t ASCII_PRINT_LO = 8'h20;
  localparam ascii_byte_t ASCII_PRINT_HI = 8'h7E;
  localparam ascii_byte_t ASCII_LF       = 8'h0A;

endpackage

// File: rtl/ascii_stream_fifo_if.sv
// rtl/ascii_stream_fifo_if.sv - byte stream handshake bundle for ascii_stream_fifo
//
// Purpose: groups the input and output valid/ready byte handshakes.
// Signals: in_data/in_valid/in_ready   producer -> fifo
//          out_data/out_valid/out_ready fifo -> consumer
// Modports: master = producer/consumer side, slave = fifo side.
interface ascii_stream_fifo_if;
  import ascii_pkg::*;

  ascii_byte_t in_data;
  logic        in_valid;
  logic        in_ready;
  ascii_byte_t out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/ascii_classify.sv
// rtl/ascii_classify.sv - printable-ASCII classifier
//
// Purpose: flags bytes in 0x20..0x7E or LF as printable.
// Ports:   x            input  byte to classify
//          is_printable output 1 when x is in the printable set
module ascii_classify
  import ascii_pkg::*;
(
  input  ascii_byte_t x,
  output logic        is_printable
);

  always_comb begin
    is_printable = ((x >= ASCII_PRINT_LO) && (x <= ASCII_PRINT_HI)) || (x == ASCII_LF);
  end

endmodule

// File: rtl/ascii_stream_fifo.sv
// rtl/ascii_stream_fifo.sv - filtering ASCII byte FIFO
//
// Purpose: stores accepted bytes in order; with FILTER_EN non-printable bytes
//          are dropped at the input and counted. One cycle write-to-read.
// Ports:   clk       rising-edge clock
//          rst_n     asynchronous active-low reset
//          bus       stream handshakes (slave side)
//          flush     synchronous queue clear, wins over store/remove
//          level     number of stored entries
//          drop_cnt  saturating count of filtered bytes
module ascii_stream_fifo
  import ascii_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit FILTER_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ascii_stream_fifo_if.slave       bus,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  ascii_byte_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic is_printable;
  logic accept, store, pop, drop;

  ascii_classify u_classify (
    .x            (bus.in_data),
    .is_printable (is_printable)
  );

  // Ready/valid derive from occupancy only, so neither side sees a
  // combinational path from the other.
  assign bus.in_ready  = (level_q != LW'(DEPTH));
  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign level         = level_q;
  assign drop_cnt      = drop_cnt_q;

  always_comb begin
    accept = bus.in_valid && bus.in_ready;
    // Bytes accepted during a flush are swallowed and not counted.
    store  = accept && !flush && (is_printable || !FILTER_EN);
    drop   = accept && !flush && !is_printable && FILTER_EN;
    pop    = bus.out_valid && bus.out_ready && !flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (store && !pop)      level_d = level_q + LW'(1);
      else if (pop && !store) level_d = level_q - LW'(1);
    end
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage holds no reset; out_data is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= bus.in_data;
  end

endmodule

// File: tb/tb_ascii_stream_fifo.sv
// tb/tb_ascii_stream_fifo.sv - self-checking bench for ascii_stream_fifo
module tb_ascii_stream_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       flush;

  logic [3:0] level1, level0;
  logic [7:0] drop1_dut, drop0_dut;

  ascii_stream_fifo_if bus1 ();
  ascii_stream_fifo_if bus0 ();

  assign bus1.in_data   = in_data;
  assign bus1.in_valid  = in_valid;
  assign bus1.out_ready = out_ready;
  assign bus0.in_data   = in_data;
  assign bus0.in_valid  = in_valid;
  assign bus0.out_ready = out_ready;

  ascii_stream_fifo #(.DEPTH(8), .FILTER_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .flush(flush),
    .level(level1), .drop_cnt(drop1_dut)
  );

  ascii_stream_fifo #(.DEPTH(8), .FILTER_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .flush(flush),
    .level(level0), .drop_cnt(drop0_dut)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue per instance and a drop counter.
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  int         drop1 = 0;
  bit         acc1, acc0;

  function automatic bit printable(input logic [7:0] b);
    return (b inside {[8'h20:8'h7E], 8'h0A});
  endfunction

  always @(negedge rst_n) begin
    q1.delete();
    q0.delete();
    drop1 = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      acc1 = in_valid && (q1.size() != 8);
      acc0 = in_valid && (q0.size() != 8);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (out_ready && q1.size() != 0) void'(q1.pop_front());
        if (out_ready && q0.size() != 0) void'(q0.pop_front());
        if (acc1 && printable(in_data)) q1.push_back(in_data);
        if (acc1 && !printable(in_data) && drop1 < 255) drop1++;
        if (acc0) q0.push_back(in_data);
      end
    end
  end

  // Per-cycle compare plus capture of the filtered DUT's output stream.
  logic [7:0] log1[$];
  logic [7:0] exp_q[$];
  int         maxlvl = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("level",      int'(level1),         q1.size());
      chk("in_ready",   int'(bus1.in_ready),  int'(q1.size() != 8));
      chk("out_valid",  int'(bus1.out_valid), int'(q1.size() != 0));
      chk("out_data",   int'(bus1.out_data),  (q1.size() != 0) ? int'(q1[0]) : 0);
      chk("drop_cnt",   int'(drop1_dut),      drop1);
      chk("f0_level",   int'(level0),         q0.size());
      chk("f0_out_data", int'(bus0.out_data), (q0.size() != 0) ? int'(q0[0]) : 0);
      chk("f0_drop_cnt", int'(drop0_dut),     0);
      if (bus1.out_valid && out_ready && !flush) log1.push_back(bus1.out_data);
      if (int'(level1) > maxlvl) maxlvl = int'(level1);
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, log1.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log1.size(); i++)
      chk(name, int'(log1[i]), int'(exp_q[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 0; in_data = 0; out_ready = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level",     int'(level1),         0);
    chk("rst_out_valid", int'(bus1.out_valid), 0);
    chk("rst_in_ready",  int'(bus1.in_ready),  1);
    chk("rst_out_data",  int'(bus1.out_data),  0);
    chk("rst_drop_cnt",  int'(drop1_dut),      0);
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0);

    // 'a','b','c' then drain
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 0, 0);
    step(1, 8'h63, 0, 0);
    chk("abc_level", int'(level1), 3);
    chk("abc_head",  int'(bus1.out_data), 8'h61);
    log1.delete();
    repeat (3) step(0, 8'h00, 1, 0);
    exp_q = '{8'h61, 8'h62, 8'h63};
    chk_log("abc_order");
    chk("abc_empty", int'(level1), 0);

    // Fill to full, 9th byte held off, pop frees space next cycle
    for (int i = 0; i < 8; i++) step(1, 8'(8'h41 + i), 0, 0);
    chk("full_level",    int'(level1),        8);
    chk("full_in_ready", int'(bus1.in_ready), 0);
    log1.delete();
    step(1, 8'h49, 0, 0);
    chk("full_hold_level", int'(level1), 8);
    step(1, 8'h49, 1, 0);
    chk("after_pop_level",    int'(level1),        7);
    chk("after_pop_in_ready", int'(bus1.in_ready), 1);
    step(1, 8'h49, 0, 0);
    chk("refill_level", int'(level1), 8);
    repeat (8) step(0, 8'h00, 1, 0);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h41 + i));
    chk_log("full_order");

    // Filtering
    log1.delete();
    step(1, 8'h07, 0, 0);
    step(1, 8'h41, 0, 0);
    step(1, 8'h7F, 0, 0);
    step(1, 8'h0A, 0, 0);
    chk("filt_level",    int'(level1),    2);
    chk("filt_f0_level", int'(level0),    4);
    chk("filt_drop",     int'(drop1_dut), 2);
    repeat (4) step(0, 8'h00, 1, 0);
    exp_q = '{8'h41, 8'h0A};
    chk_log("filt_order");
    repeat (300) step(1, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("drop_sat", int'(drop1_dut), 255);

    // Streaming through with wrap
    log1.delete();
    maxlvl = 0;
    for (int i = 0; i < 40; i++) step(1, 8'(8'h20 + i), 1, 0);
    step(0, 8'h00, 1, 0);
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back(8'(8'h20 + i));
    chk_log("stream_order");
    chk("stream_max_level", maxlvl, 1);

    // Flush wins over simultaneous push and pop
    for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0);
    chk("pre_flush_level", int'(level1), 5);
    log1.delete();
    step(1, 8'h35, 1, 1);
    chk("flush_level",     int'(level1),         0);
    chk("flush_out_valid", int'(bus1.out_valid), 0);
    chk("flush_f0_level",  int'(level0),         0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    exp_q.delete();
    chk_log("flush_nothing");
    chk("flush_drop_kept", int'(drop1_dut), 255);

    // Reset mid-transfer
    for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i), 0, 0);
    chk("pre_rst_level", int'(level1), 4);
    in_valid = 0; out_ready = 1; flush = 0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", int'(bus1.out_valid), 0);
    chk("rst_mid_level",     int'(level1),         0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_level",    int'(level1),        0);
    chk("post_rst_drop",     int'(drop1_dut),     0);
    chk("post_rst_in_ready", int'(bus1.in_ready), 1);
    log1.delete();
    repeat (3) step(0, 8'h00, 1, 0);
    exp_q.delete();
    chk_log("post_rst_nothing");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascii_stream_fifo.md
ASCII_STREAM_FIFO -- requirements
Module: ascii_stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of byte entries (power of two, 2 to 64).
REQ-002 SHALL have parameter FILTER_EN, default 1, meaning non-printable bytes are discarded at the input when 1.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_data  input  8  incoming ASCII byte.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_data  output  8  head-of-queue byte; drives the case-converter input x.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 flush  input  1  synchronous queue clear.
REQ-013 level  output  clog2(DEPTH)+1  number of stored entries.
REQ-014 drop_cnt  output  8  saturating count of filtered bytes.

Function
REQ-015 A byte SHALL be accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-016 in_ready SHALL equal (level != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-017 Printable set SHALL be 0x20..0x7E plus 0x0A (LF); with FILTER_EN=1 an accepted byte outside the set SHALL be discarded, not stored, and drop_cnt incremented by 1.
REQ-018 drop_cnt SHALL saturate at 255 and hold.
REQ-019 With FILTER_EN=0 every accepted byte SHALL be stored and drop_cnt SHALL stay 0.
REQ-020 out_valid SHALL equal (level != 0); out_data SHALL be the oldest stored byte, stable while out_valid=1 and out_ready=0.
REQ-021 A byte SHALL be removed when out_valid and out_ready are both 1 on a rising clk edge.
REQ-022 Write-to-read latency SHALL be 1 cycle: a byte stored into an empty queue at edge N appears on out_data with out_valid=1 after edge N; no combinational pass-through.
REQ-023 Simultaneous store and remove SHALL leave level unchanged and preserve order.
REQ-024 When full, in_ready=0 even if out_ready=1 in the same cycle; space frees one cycle after the pop.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-026 flush=1 SHALL, at the next edge, set level to 0 and discard all contents; flush SHALL take priority over a simultaneous store or remove; drop_cnt unaffected.
REQ-027 During a flush cycle in_ready SHALL still follow REQ-016 but any byte accepted SHALL be discarded and not counted.
REQ-028 Byte order at the output SHALL equal the order of stored (non-discarded) input bytes.

Reset
REQ-029 On rst_n=0, asynchronously: level=0, out_valid=0, in_ready=1 after release, drop_cnt=0, pointers=0.
REQ-030 out_data SHALL read 0x00 while out_valid=0 after reset; storage array need not be reset.
REQ-031 Reset asserted mid-transfer SHALL abandon all stored bytes; no stored byte SHALL appear after release.

Structure
REQ-032 Shared package ascii_pkg SHALL hold ASCII_PRINT_LO=0x20, ASCII_PRINT_HI=0x7E, ASCII_LF=0x0A and the byte type.
REQ-033 The printable test SHALL be a sub-module ascii_classify (8-bit input, 1-bit is_printable output), reusable by the case-conversion stage.
REQ-034 Storage SHALL be a register array of DEPTH x 8 bits with separate read/write pointers and an occupancy counter.

Verification
REQ-035 Reset, then push 'a','b','c' (0x61,0x62,0x63) with out_ready=0 -> level=3, out_data=0x61; then out_ready=1 -> 0x61,0x62,0x63 on consecutive cycles, level=0.
REQ-036 Push 9 bytes with DEPTH=8, out_ready=0 -> in_ready=0 after 8th, level=8, 9th byte held by source; pop one -> in_ready=1 next cycle.
REQ-037 FILTER_EN=1, push 0x07, 0x41, 0x7F, 0x0A -> output 0x41, 0x0A only; drop_cnt=2; 300 pushes of 0x00 -> drop_cnt=255.
REQ-038 Continuous push and pop with out_ready=1 for 40 bytes 0x20..0x47 -> identical order out, level never exceeds 1, pointers wrap cleanly.
REQ-039 level=5, assert flush with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, neither byte appears.
REQ-040 level=4, drop rst_n mid-cycle -> out_valid=0 immediately; after release level=0, drop_cnt=0, in_ready=1.
